tablero_nxn: RTL

Parametrised successor to the 3×3 board and winner pair: one block that stores an N×N board and detects K-in-a-row for the two players. Placement uses the existing `colocar`/`colocado` handshake. After each accepted placement, a sequential line-scan FSM checks only the lines through the newly placed cell, in four directions. The block also reports draws and rejected moves, and sits between the game-control FSM and the display/score logic.

---
 rtl/tablero_nxn.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tablero_nxn.sv
// tablero_nxn: N x N two-player board with K-in-a-row detection.
//
// A placement request (colocar) is accepted only while idle, in range and on
// an empty cell. Each accepted mark triggers a fixed-latency sweep over the
// four lines through the new cell: forward then backward, K-1 cells each way,
// one cell per cycle. The win/draw decision is taken once the sweep ends.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   pos      target cell, row-major (fila*N + col)
//   jugador  player placing the mark
//   colocar  placement request, sampled every edge
//   colocado one-cycle pulse: placement accepted and written
//   rechazo  one-cycle pulse: placement refused
//   busy     high while a placement is being evaluated
//   matriz   board, 2 bits per cell (00 empty, 01 player 0, 10 player 1)
//   win      sticky: a player completed K in a row
//   ganador  winning player (0 unless win)
//   empate   sticky: board full with no winner
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a placement
// CHECK  | sweeping the four lines through the last placed cell
// FINAL  | deciding win / draw from the sweep result
// OVER   | game finished, only reset leaves this state
module tablero_nxn #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int PW = $clog2(N*N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PW-1:0]    pos,
    input  logic             jugador,
    input  logic             colocar,
    output logic             colocado,
    output logic             rechazo,
    output logic             busy,
    output logic [N*N*2-1:0] matriz,
    output logic             win,
    output logic             ganador,
    output logic             empate
);
    localparam int NC   = N * N;
    localparam int CW   = $clog2(N) + 2;     // signed coordinate, room for off-board excursions
    localparam int CNTW = $clog2(2 * K);
    localparam int SW   = $clog2(K);
    localparam logic [SW-1:0]   STEP_LOAD = SW'(K - 2);
    localparam logic [CNTW-1:0] RUN_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] RUN_WIN   = CNTW'(K);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FINAL, S_OVER} state_t;

    state_t               state_q;
    logic [1:0]           cell_q [NC];
    logic                 ply_q;
    logic signed [CW-1:0] org_r, org_c;
    logic signed [CW-1:0] cur_r, cur_c;
    logic [1:0]           dir_q;
    logic                 bwd_q;
    logic [SW-1:0]        step_q;
    logic                 alive_q;
    logic [CNTW-1:0]      cnt_q;
    logic                 found_q;
    logic                 tail_q;

    // Unit step per direction: d0 (0,+1), d1 (+1,0), d2 (+1,+1), d3 (+1,-1)
    function automatic logic signed [CW-1:0] step_r(input logic [1:0] d);
        return (d == 2'd0) ? '0 : CW'(1);
    endfunction

    function automatic logic signed [CW-1:0] step_c(input logic [1:0] d);
        case (d)
            2'd0, 2'd2: return CW'(1);
            2'd1:       return '0;
            default:    return '1;
        endcase
    endfunction

    logic                 pos_in, pos_occ, acc_ok;
    logic signed [CW-1:0] pos_r, pos_c;
    logic signed [CW-1:0] fdr, fdc, sdr, sdc, ndr, ndc;
    logic                 on_board, hit, full;
    logic [1:0]           cell_at, mark;
    logic [CNTW-1:0]      cnt_nxt;
    int                   r_i, c_i;

    always_comb begin
        pos_in  = int'(pos) < NC;
        pos_occ = 1'b0;
        pos_r   = '0;
        pos_c   = '0;
        for (int i = 0; i < NC; i++) begin
            if (int'(pos) == i) begin
                pos_occ = (cell_q[i] != 2'b00);
                pos_r   = CW'(i / N);
                pos_c   = CW'(i % N);
            end
        end
        acc_ok = (state_q == S_IDLE) && colocar && pos_in && !pos_occ;

        fdr = step_r(dir_q);
        fdc = step_c(dir_q);
        sdr = bwd_q ? -fdr : fdr;
        sdc = bwd_q ? -fdc : fdc;
        ndr = step_r(dir_q + 2'd1);
        ndc = step_c(dir_q + 2'd1);

        // Bounds on row/column so a row wrap never looks adjacent
        r_i      = int'(cur_r);
        c_i      = int'(cur_c);
        on_board = (r_i >= 0) && (r_i < N) && (c_i >= 0) && (c_i < N);
        cell_at  = 2'b00;
        for (int i = 0; i < NC; i++) begin
            if (on_board && ((r_i * N + c_i) == i)) begin
                cell_at = cell_q[i];
            end
        end
        mark    = {ply_q, ~ply_q};
        hit     = on_board && (cell_at == mark);
        cnt_nxt = cnt_q + ((alive_q && hit) ? RUN_ONE : '0);

        full = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (cell_q[i] == 2'b00) begin
                full = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_mat
        assign matriz[2*g +: 2] = cell_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                cell_q[i] <= 2'b00;
            end
            state_q  <= S_IDLE;
            colocado <= 1'b0;
            rechazo  <= 1'b0;
            busy     <= 1'b0;
            win      <= 1'b0;
            ganador  <= 1'b0;
            empate   <= 1'b0;
            ply_q    <= 1'b0;
            org_r    <= '0;
            org_c    <= '0;
            cur_r    <= '0;
            cur_c    <= '0;
            dir_q    <= '0;
            bwd_q    <= 1'b0;
            step_q   <= '0;
            alive_q  <= 1'b0;
            cnt_q    <= '0;
            found_q  <= 1'b0;
            tail_q   <= 1'b0;
        end else begin
            colocado <= 1'b0;
            rechazo  <= colocar && !acc_ok;
            case (state_q)
                S_IDLE: begin
                    if (acc_ok) begin
                        cell_q[pos] <= {jugador, ~jugador};
                        ply_q       <= jugador;
                        org_r       <= pos_r;
                        org_c       <= pos_c;
                        cur_r       <= pos_r + step_r(2'd0);
                        cur_c       <= pos_c + step_c(2'd0);
                        dir_q       <= 2'd0;
                        bwd_q       <= 1'b0;
                        step_q      <= STEP_LOAD;
                        alive_q     <= 1'b1;
                        cnt_q       <= RUN_ONE;
                        found_q     <= 1'b0;
                        tail_q      <= 1'b0;
                        busy        <= 1'b1;
                        colocado    <= 1'b1;
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (tail_q) begin
                        // one trailing cycle after the last step keeps the latency at 8(K-1)+2
                        state_q <= S_FINAL;
                    end else if (step_q == '0) begin
                        alive_q <= 1'b1;
                        step_q  <= STEP_LOAD;
                        if (!bwd_q) begin
                            bwd_q <= 1'b1;
                            cnt_q <= cnt_nxt;
                            cur_r <= org_r - fdr;
                            cur_c <= org_c - fdc;
                        end else begin
                            found_q <= found_q | (cnt_nxt >= RUN_WIN);
                            cnt_q   <= RUN_ONE;
                            bwd_q   <= 1'b0;
                            dir_q   <= dir_q + 2'd1;
                            cur_r   <= org_r + ndr;
                            cur_c   <= org_c + ndc;
                            if (dir_q == 2'd3) begin
                                tail_q <= 1'b1;
                            end
                        end
                    end else begin
                        step_q  <= step_q - 1'b1;
                        cnt_q   <= cnt_nxt;
                        alive_q <= alive_q & hit;
                        cur_r   <= cur_r + sdr;
                        cur_c   <= cur_c + sdc;
                    end
                end
                S_FINAL: begin
                    busy <= 1'b0;
                    if (found_q) begin
                        win     <= 1'b1;
                        ganador <= ply_q;
                        state_q <= S_OVER;
                    end else if (full) begin
                        empate  <= 1'b1;
                        state_q <= S_OVER;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
